exe_decode_stage: RTL and testbench

Registered, multi-lane execute-decode stage between issue/register-read and the execution units of the out-of-order RV32I core. Each cycle it accepts a bundle of up to ISSUE_W micro-ops and expands each op's opcode into ALU function, operand-2 select, branch function and a full 32-bit immediate. Results are held in a 2-entry skid buffer so that upstream ready is a registered signal. The stage supports a whole-pipeline flush and a per-lane kill on branch mispredict.

---
 rtl/exe_decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_exe_decode_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_decode_stage.sv
// rtl/exe_decode_stage.sv - multi-lane execute-decode stage with a 2-entry registered skid buffer
// Expands micro-opcodes into ALU/branch controls and 32-bit immediates; supports flush and tag kill.
package uopc;
  typedef enum logic [4:0] {
    UOP_NOP, UOP_LUI, UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI, UOP_ANDI,
    UOP_SLLI, UOP_SRLI, UOP_SRAI, UOP_ADD, UOP_SUB, UOP_SLL, UOP_SLT, UOP_SLTU,
    UOP_XOR, UOP_SRL, UOP_SRA, UOP_OR, UOP_AND, UOP_JAL, UOP_JALR, UOP_BEQ,
    UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU, UOP_LW, UOP_SW
  } micro_opcode_t;
endpackage

package immt;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
endpackage

package brfnt;
  typedef enum logic [2:0] {
    BR_NONE, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_func_t;
endpackage

package alufnt;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_func_t;
endpackage

package opr2t;
  typedef enum logic {OPR2_IMM, OPR2_RS2} opr2_sel_t;
endpackage

module exe_decode_stage #(
  parameter int ISSUE_W = 2,
  parameter int TAG_W   = 6,
  parameter int PREG_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ISSUE_W-1:0]    in_valid,
  output logic                  in_ready,
  input  uopc::micro_opcode_t   in_uopcode    [ISSUE_W],
  input  logic [19:0]           in_packed_imm [ISSUE_W],
  input  immt::imm_type_t       in_imm_type   [ISSUE_W],
  input  logic [TAG_W-1:0]      in_tag        [ISSUE_W],
  input  logic [PREG_W-1:0]     in_pdst       [ISSUE_W],
  output logic [ISSUE_W-1:0]    out_valid,
  input  logic                  out_ready,
  output alufnt::alu_func_t     out_alufn     [ISSUE_W],
  output opr2t::opr2_sel_t      out_opr2      [ISSUE_W],
  output brfnt::br_func_t       out_brfn      [ISSUE_W],
  output logic [31:0]           out_imm       [ISSUE_W],
  output logic [TAG_W-1:0]      out_tag       [ISSUE_W],
  output logic [PREG_W-1:0]     out_pdst      [ISSUE_W],
  input  logic                  flush,
  input  logic                  kill_valid,
  input  logic [TAG_W-1:0]      kill_tag
);

  typedef struct packed {
    logic                v;
    alufnt::alu_func_t   alufn;
    opr2t::opr2_sel_t    opr2;
    brfnt::br_func_t     brfn;
    logic [31:0]         imm;
    logic [TAG_W-1:0]    tag;
    logic [PREG_W-1:0]   pdst;
  } lane_t;

  typedef lane_t [ISSUE_W-1:0] bundle_t;

  bundle_t    head_q, skid_q;
  bundle_t    head_k, skid_k, new_k;
  bundle_t    head_d, skid_d;
  logic [1:0] n_held;
  logic       fire_in, fire_out;

  function automatic logic [31:0] expand_imm(immt::imm_type_t t, logic [19:0] p);
    case (t)
      immt::IMM_B: expand_imm = {{20{p[19]}}, p[8], p[18:9], 1'b0};
      immt::IMM_J: expand_imm = {{12{p[19]}}, p[7:0], p[8], p[18:9], 1'b0};
      immt::IMM_U: expand_imm = {p, 12'b0};
      default:     expand_imm = {{20{p[19]}}, p[19:8]};
    endcase
  endfunction

  function automatic lane_t decode(uopc::micro_opcode_t u, immt::imm_type_t t, logic [19:0] p,
                                   logic [TAG_W-1:0] tag, logic [PREG_W-1:0] pdst, logic v);
    lane_t l;
    l.v     = v;
    l.alufn = alufnt::ALU_ADD;
    l.opr2  = opr2t::OPR2_IMM;
    l.brfn  = brfnt::BR_NONE;
    l.imm   = expand_imm(t, p);
    l.tag   = tag;
    l.pdst  = pdst;
    // lui and addi keep the add/imm default
    case (u)
      uopc::UOP_SLTI:  l.alufn = alufnt::ALU_SLT;
      uopc::UOP_SLTIU: l.alufn = alufnt::ALU_SLTU;
      uopc::UOP_XORI:  l.alufn = alufnt::ALU_XOR;
      uopc::UOP_ORI:   l.alufn = alufnt::ALU_OR;
      uopc::UOP_ANDI:  l.alufn = alufnt::ALU_AND;
      uopc::UOP_SLLI:  l.alufn = alufnt::ALU_SLL;
      uopc::UOP_SRLI:  l.alufn = alufnt::ALU_SRL;
      uopc::UOP_SRAI:  l.alufn = alufnt::ALU_SRA;
      uopc::UOP_ADD:   l.opr2  = opr2t::OPR2_RS2;
      uopc::UOP_SUB:   begin l.alufn = alufnt::ALU_SUB;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_SLL:   begin l.alufn = alufnt::ALU_SLL;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_SLT:   begin l.alufn = alufnt::ALU_SLT;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_SLTU:  begin l.alufn = alufnt::ALU_SLTU; l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_XOR:   begin l.alufn = alufnt::ALU_XOR;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_SRL:   begin l.alufn = alufnt::ALU_SRL;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_SRA:   begin l.alufn = alufnt::ALU_SRA;  l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_OR:    begin l.alufn = alufnt::ALU_OR;   l.opr2 = opr2t::OPR2_RS2; end
      uopc::UOP_AND:   begin l.alufn = alufnt::ALU_AND;  l.opr2 = opr2t::OPR2_RS2; end
      default: ;
    endcase
    case (u)
      uopc::UOP_JALR: l.brfn = brfnt::BR_JALR;
      uopc::UOP_BEQ:  l.brfn = brfnt::BR_BEQ;
      uopc::UOP_BNE:  l.brfn = brfnt::BR_BNE;
      uopc::UOP_BLT:  l.brfn = brfnt::BR_BLT;
      uopc::UOP_BGE:  l.brfn = brfnt::BR_BGE;
      uopc::UOP_BLTU: l.brfn = brfnt::BR_BLTU;
      uopc::UOP_BGEU: l.brfn = brfnt::BR_BGEU;
      default: ;
    endcase
    return l;
  endfunction

  function automatic logic any_valid(bundle_t b);
    logic a;
    a = 1'b0;
    for (int i = 0; i < ISSUE_W; i++) a |= b[i].v;
    return a;
  endfunction

  assign fire_in  = (|in_valid) & in_ready & ~flush;
  assign fire_out = (|out_valid) & out_ready;

  // Kill is applied to held lanes and to the bundle being written in the same cycle
  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      head_k[i] = head_q[i];
      skid_k[i] = skid_q[i];
      if (kill_valid && head_q[i].tag == kill_tag) head_k[i].v = 1'b0;
      if (kill_valid && skid_q[i].tag == kill_tag) skid_k[i].v = 1'b0;
      new_k[i] = decode(in_uopcode[i], in_imm_type[i], in_packed_imm[i], in_tag[i], in_pdst[i],
                        in_valid[i] & ~(kill_valid && in_tag[i] == kill_tag));
    end
  end

  // An entry is occupied only while it has a live lane, so fully killed bundles vanish and
  // the survivors compact toward the head in arrival order.
  always_comb begin
    head_d = head_k;
    skid_d = skid_k;
    n_held = 2'd0;
    if (!fire_out && any_valid(head_k)) n_held = 2'd1;
    if (any_valid(skid_k)) begin
      if (n_held == 2'd0) head_d = skid_k;
      else                skid_d = skid_k;
      n_held = n_held + 2'd1;
    end
    if (fire_in && any_valid(new_k)) begin
      if (n_held == 2'd0) head_d = new_k;
      else                skid_d = new_k;
      n_held = n_held + 2'd1;
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      if (n_held == 2'd0) head_d[i].v = 1'b0;
      if (n_held < 2'd2)  skid_d[i].v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      skid_q   <= '0;
      in_ready <= 1'b1;
    end else if (flush) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        head_q[i].v <= 1'b0;
        skid_q[i].v <= 1'b0;
      end
      in_ready <= 1'b1;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      in_ready <= (n_held < 2'd2);
    end
  end

  always_comb begin
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i] = head_q[i].v;
      out_alufn[i] = head_q[i].alufn;
      out_opr2[i]  = head_q[i].opr2;
      out_brfn[i]  = head_q[i].brfn;
      out_imm[i]   = head_q[i].imm;
      out_tag[i]   = head_q[i].tag;
      out_pdst[i]  = head_q[i].pdst;
    end
  end

endmodule

// File: tb/tb_exe_decode_stage.sv
// tb/tb_exe_decode_stage.sv - self-checking bench for exe_decode_stage against a bundle-queue model
module tb_exe_decode_stage;
  localparam int IW = 2;
  localparam int TW = 6;
  localparam int PW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [IW-1:0]       in_valid;
  logic                in_ready;
  uopc::micro_opcode_t in_uopcode    [IW];
  logic [19:0]         in_packed_imm [IW];
  immt::imm_type_t     in_imm_type   [IW];
  logic [TW-1:0]       in_tag        [IW];
  logic [PW-1:0]       in_pdst       [IW];
  logic [IW-1:0]       out_valid;
  logic                out_ready;
  alufnt::alu_func_t   out_alufn     [IW];
  opr2t::opr2_sel_t    out_opr2      [IW];
  brfnt::br_func_t     out_brfn      [IW];
  logic [31:0]         out_imm       [IW];
  logic [TW-1:0]       out_tag       [IW];
  logic [PW-1:0]       out_pdst      [IW];
  logic                flush;
  logic                kill_valid;
  logic [TW-1:0]       kill_tag;

  exe_decode_stage #(.ISSUE_W(IW), .TAG_W(TW), .PREG_W(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_uopcode(in_uopcode), .in_packed_imm(in_packed_imm), .in_imm_type(in_imm_type),
    .in_tag(in_tag), .in_pdst(in_pdst), .out_valid(out_valid), .out_ready(out_ready),
    .out_alufn(out_alufn), .out_opr2(out_opr2), .out_brfn(out_brfn), .out_imm(out_imm),
    .out_tag(out_tag), .out_pdst(out_pdst), .flush(flush), .kill_valid(kill_valid),
    .kill_tag(kill_tag)
  );

  typedef struct packed {
    logic              v;
    alufnt::alu_func_t alufn;
    opr2t::opr2_sel_t  opr2;
    brfnt::br_func_t   brfn;
    logic [31:0]       imm;
    logic [TW-1:0]     tag;
    logic [PW-1:0]     pdst;
  } xlane_t;
  typedef xlane_t [IW-1:0] xbundle_t;

  xbundle_t q[$];
  logic     ready_m;
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  function automatic alufnt::alu_func_t ref_alu(uopc::micro_opcode_t u);
    case (u)
      uopc::UOP_SUB:                   return alufnt::ALU_SUB;
      uopc::UOP_SLL,  uopc::UOP_SLLI:  return alufnt::ALU_SLL;
      uopc::UOP_SLT,  uopc::UOP_SLTI:  return alufnt::ALU_SLT;
      uopc::UOP_SLTU, uopc::UOP_SLTIU: return alufnt::ALU_SLTU;
      uopc::UOP_XOR,  uopc::UOP_XORI:  return alufnt::ALU_XOR;
      uopc::UOP_SRL,  uopc::UOP_SRLI:  return alufnt::ALU_SRL;
      uopc::UOP_SRA,  uopc::UOP_SRAI:  return alufnt::ALU_SRA;
      uopc::UOP_OR,   uopc::UOP_ORI:   return alufnt::ALU_OR;
      uopc::UOP_AND,  uopc::UOP_ANDI:  return alufnt::ALU_AND;
      default:                         return alufnt::ALU_ADD;
    endcase
  endfunction

  function automatic opr2t::opr2_sel_t ref_opr2(uopc::micro_opcode_t u);
    if (u inside {uopc::UOP_ADD, uopc::UOP_SUB, uopc::UOP_SLL, uopc::UOP_SLT, uopc::UOP_SLTU,
                  uopc::UOP_XOR, uopc::UOP_SRL, uopc::UOP_SRA, uopc::UOP_OR, uopc::UOP_AND})
      return opr2t::OPR2_RS2;
    return opr2t::OPR2_IMM;
  endfunction

  function automatic brfnt::br_func_t ref_br(uopc::micro_opcode_t u);
    case (u)
      uopc::UOP_JALR: return brfnt::BR_JALR;
      uopc::UOP_BEQ:  return brfnt::BR_BEQ;
      uopc::UOP_BNE:  return brfnt::BR_BNE;
      uopc::UOP_BLT:  return brfnt::BR_BLT;
      uopc::UOP_BGE:  return brfnt::BR_BGE;
      uopc::UOP_BLTU: return brfnt::BR_BLTU;
      uopc::UOP_BGEU: return brfnt::BR_BGEU;
      default:        return brfnt::BR_NONE;
    endcase
  endfunction

  // Immediates as signed offsets built arithmetically from the packed fields
  function automatic logic [31:0] ref_imm(immt::imm_type_t t, logic [19:0] p);
    int          v;
    logic [31:0] w;
    w = {12'b0, p};
    case (t)
      immt::IMM_B: begin
        v = (int'(p[19]) << 12) + (int'(p[8]) << 11) + (int'((w >> 9) & 32'h3FF) << 1);
        if (v >= 4096) v -= 8192;
      end
      immt::IMM_J: begin
        v = (int'(p[19]) << 20) + (int'(w & 32'hFF) << 12) + (int'(p[8]) << 11)
          + (int'((w >> 9) & 32'h3FF) << 1);
        if (v >= (1 << 20)) v -= (1 << 21);
      end
      immt::IMM_U: return w * 32'd4096;
      default: begin
        v = int'(w >> 8);
        if (v >= 2048) v -= 4096;
      end
    endcase
    return 32'(v);
  endfunction

  function automatic logic live(xbundle_t b);
    return b[0].v | b[1].v;
  endfunction

  task automatic model_update();
    xbundle_t nb, e;
    logic     fo, fi;
    for (int i = 0; i < IW; i++) begin
      nb[i].v     = in_valid[i] && !(kill_valid && in_tag[i] == kill_tag);
      nb[i].alufn = ref_alu(in_uopcode[i]);
      nb[i].opr2  = ref_opr2(in_uopcode[i]);
      nb[i].brfn  = ref_br(in_uopcode[i]);
      nb[i].imm   = ref_imm(in_imm_type[i], in_packed_imm[i]);
      nb[i].tag   = in_tag[i];
      nb[i].pdst  = in_pdst[i];
    end
    if (rst || flush) begin
      q.delete();
      ready_m = 1'b1;
    end else begin
      fo = (q.size() > 0) && out_ready;
      fi = (|in_valid) && ready_m;
      if (fo) void'(q.pop_front());
      for (int k = q.size() - 1; k >= 0; k--) begin
        e = q[k];
        for (int i = 0; i < IW; i++) if (kill_valid && e[i].tag == kill_tag) e[i].v = 1'b0;
        if (live(e)) q[k] = e;
        else q.delete(k);
      end
      if (fi && live(nb)) q.push_back(nb);
      ready_m = (q.size() < 2);
    end
  endtask

  task automatic compare();
    xbundle_t      h;
    logic [IW-1:0] ev;
    ev = '0;
    h  = '0;
    if (q.size() > 0) begin
      h = q[0];
      for (int i = 0; i < IW; i++) ev[i] = h[i].v;
    end
    chk("in_ready", 64'(in_ready), 64'(ready_m));
    chk("out_valid", 64'(out_valid), 64'(ev));
    for (int i = 0; i < IW; i++) begin
      if (ev[i]) begin
        chk($sformatf("alufn%0d", i), 64'(out_alufn[i]), 64'(h[i].alufn));
        chk($sformatf("opr2_%0d", i), 64'(out_opr2[i]), 64'(h[i].opr2));
        chk($sformatf("brfn%0d", i), 64'(out_brfn[i]), 64'(h[i].brfn));
        chk($sformatf("imm%0d", i), 64'(out_imm[i]), 64'(h[i].imm));
        chk($sformatf("tag%0d", i), 64'(out_tag[i]), 64'(h[i].tag));
        chk($sformatf("pdst%0d", i), 64'(out_pdst[i]), 64'(h[i].pdst));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input uopc::micro_opcode_t u, input immt::imm_type_t t,
                          input logic [19:0] p, input logic [TW-1:0] tag);
    in_uopcode[i]    = u;
    in_imm_type[i]   = t;
    in_packed_imm[i] = p;
    in_tag[i]        = tag;
    in_pdst[i]       = PW'(tag + 6'd7);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < IW; i++) begin
      chk("rst_alufn", 64'(out_alufn[i]), 64'(alufnt::ALU_ADD));
      chk("rst_opr2", 64'(out_opr2[i]), 64'(opr2t::OPR2_IMM));
      chk("rst_brfn", 64'(out_brfn[i]), 64'(brfnt::BR_NONE));
      chk("rst_imm", 64'(out_imm[i]), 64'd0);
      chk("rst_tag", 64'(out_tag[i]), 64'd0);
      chk("rst_pdst", 64'(out_pdst[i]), 64'd0);
    end
  endtask

  task automatic fill_two(input logic [TW-1:0] base);
    out_ready = 1'b0;
    in_valid  = 2'b11;
    set_lane(0, uopc::UOP_ADD, immt::IMM_I, 20'h00100, base);
    set_lane(1, uopc::UOP_ORI, immt::IMM_I, 20'h80000, base + 6'd1);
    step();
    set_lane(0, uopc::UOP_SRAI, immt::IMM_I, 20'h00500, base + 6'd2);
    set_lane(1, uopc::UOP_BGE, immt::IMM_B, 20'h7FE00, base + 6'd3);
    step();
  endtask

  initial begin
    ready_m    = 1'b1;
    rst        = 1'b1;
    flush      = 1'b0;
    kill_valid = 1'b0;
    kill_tag   = '0;
    in_valid   = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < IW; i++) set_lane(i, uopc::UOP_NOP, immt::IMM_I, 20'h0, '0);
    step();
    step();
    rst = 1'b0;
    check_reset_values();

    // addi / lui, one-cycle latency
    set_lane(0, uopc::UOP_ADDI, immt::IMM_I, 20'hFFF00, 6'd1);
    set_lane(1, uopc::UOP_LUI, immt::IMM_U, 20'h12345, 6'd2);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    chk("d1_valid", 64'(out_valid), 64'h3);
    chk("d1_imm0", 64'(out_imm[0]), 64'hFFFFFFFF);
    chk("d1_alu0", 64'(out_alufn[0]), 64'(alufnt::ALU_ADD));
    chk("d1_opr0", 64'(out_opr2[0]), 64'(opr2t::OPR2_IMM));
    chk("d1_imm1", 64'(out_imm[1]), 64'h12345000);
    step();

    // A, B held; C stalled until the drain starts
    out_ready = 1'b0;
    in_valid  = 2'b11;
    set_lane(0, uopc::UOP_SUB, immt::IMM_I, 20'h11100, 6'd10);
    set_lane(1, uopc::UOP_XORI, immt::IMM_I, 20'h22200, 6'd11);
    step();
    set_lane(0, uopc::UOP_SLT, immt::IMM_S, 20'h33300, 6'd12);
    set_lane(1, uopc::UOP_JALR, immt::IMM_I, 20'hF0000, 6'd13);
    step();
    chk("d2_full_ready", 64'(in_ready), 64'd0);
    set_lane(0, uopc::UOP_AND, immt::IMM_J, 20'h4A5A5, 6'd14);
    set_lane(1, uopc::UOP_BLTU, immt::IMM_B, 20'hC0300, 6'd15);
    step();
    step();
    chk("d2_head_tag", 64'(out_tag[0]), 64'd10);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic acc;
      acc = ready_m;
      step();
      if (acc) in_valid = 2'b00;
    end

    // branch immediates
    set_lane(0, uopc::UOP_BNE, immt::IMM_B, 20'h80100, 6'd3);
    in_valid = 2'b01;
    step();
    chk("d3_bne_fn", 64'(out_brfn[0]), 64'(brfnt::BR_BNE));
    chk("d3_bne_imm", 64'(out_imm[0]), 64'hFFFFF800);
    set_lane(0, uopc::UOP_JAL, immt::IMM_J, 20'h000FF, 6'd4);
    step();
    in_valid = 2'b00;
    chk("d3_jal_fn", 64'(out_brfn[0]), 64'(brfnt::BR_NONE));
    chk("d3_jal_imm", 64'(out_imm[0]), 64'h000FF000);
    step();

    // per-lane kill and drop of fully killed bundles without out_ready
    out_ready = 1'b0;
    in_valid  = 2'b11;
    set_lane(0, uopc::UOP_ADDI, immt::IMM_I, 20'h00700, 6'd20);
    set_lane(1, uopc::UOP_ADD, immt::IMM_I, 20'h00800, 6'd21);
    step();
    in_valid = 2'b01;
    set_lane(0, uopc::UOP_SLLI, immt::IMM_I, 20'h00300, 6'd22);
    set_lane(1, uopc::UOP_OR, immt::IMM_I, 20'h00300, 6'd23);
    step();
    in_valid   = 2'b00;
    kill_valid = 1'b1;
    kill_tag   = 6'd21;
    step();
    chk("d4_lane_kill", 64'(out_valid), 64'h1);
    kill_tag = 6'd22;
    step();
    chk("d4_skid_drop_ready", 64'(in_ready), 64'd1);
    kill_tag = 6'd20;
    step();
    kill_valid = 1'b0;
    chk("d4_head_drop", 64'(out_valid), 64'h0);
    step();

    // flush with both entries full and a bundle on the input
    fill_two(6'd30);
    set_lane(0, uopc::UOP_SRL, immt::IMM_I, 20'h00900, 6'd40);
    set_lane(1, uopc::UOP_BEQ, immt::IMM_B, 20'h00A00, 6'd41);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 2'b00;
    chk("d5_flush_valid", 64'(out_valid), 64'h0);
    chk("d5_flush_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // reset while stalled and full
    fill_two(6'd50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values();
    set_lane(0, uopc::UOP_SLTIU, immt::IMM_U, 20'hABCDE, 6'd60);
    set_lane(1, uopc::UOP_SRA, immt::IMM_J, 20'h55555, 6'd61);
    in_valid = 2'b11;
    step();
    in_valid = 2'b00;
    chk("d6_post_rst_lat", 64'(out_valid), 64'h3);
    out_ready = 1'b1;
    step();

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < IW; i++)
        set_lane(i, uopc::micro_opcode_t'(5'($urandom_range(0, 30))),
                 immt::imm_type_t'(3'($urandom_range(0, 4))),
                 20'($urandom), 6'($urandom_range(0, 15)));
      in_valid   = 2'($urandom);
      out_ready  = ($urandom_range(0, 9) < 6);
      kill_valid = ($urandom_range(0, 5) == 0);
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        xbundle_t b;
        b        = q[$urandom_range(0, q.size() - 1)];
        kill_tag = b[$urandom_range(0, 1)].tag;
      end else begin
        kill_tag = 6'($urandom_range(0, 15));
      end
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      step();
    end
    rst        = 1'b0;
    flush      = 1'b0;
    kill_valid = 1'b0;
    in_valid   = '0;
    out_ready  = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
